shim_idle_inserter: RTL and testbench

//  Sits directly downstream of the shim FIFO (shim_fifo_buf) on the TX path, between the 64b/66b encoder and the scrambler.

---
 rtl/shim_idle_inserter.sv | 125 ++++++++++++
 tb/tb_shim_idle_inserter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shim_idle_inserter.sv
`default_nettype none
// ============================================================================
// Module   : shim_idle_inserter
// Purpose  : Registered pass-through of the 64b/66b TX block stream. Eligible
//            inter-frame IDLE blocks are replaced with queued shim blocks.
// Revision : 1.0 - initial release
// ============================================================================
module shim_idle_inserter #(
    parameter int unsigned DWIDTH  = 64,
    parameter int unsigned CWIDTH  = 2,
    parameter int unsigned MIN_IPG = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pcs_valid,
    input  logic [DWIDTH-1:0] pcs_d,
    input  logic [CWIDTH-1:0] pcs_c,
    input  logic              shim_empty,
    input  logic [DWIDTH-1:0] shim_d,
    input  logic [CWIDTH-1:0] shim_c,
    output logic              shim_rd,
    output logic              tx_valid,
    output logic [DWIDTH-1:0] tx_d,
    output logic [CWIDTH-1:0] tx_c,
    output logic [CNT_W-1:0]  ins_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [0:0]        c_ST_GAP   = 1'b0;
    localparam logic [0:0]        c_ST_FRAME = 1'b1;
    localparam logic [3:0]        c_MIN_IPG  = 4'(MIN_IPG);
    localparam logic [DWIDTH-1:0] c_IDLE_D   = DWIDTH'(8'h1e);
    localparam logic [CWIDTH-1:0] c_SH_CTRL  = CWIDTH'(2'b01);
    localparam logic [CWIDTH-1:0] c_SH_DATA  = CWIDTH'(2'b10);

    logic [0:0]        r_state;
    logic [3:0]        r_ipg_cnt;
    logic              r_tx_valid;
    logic [DWIDTH-1:0] r_tx_d;
    logic [CWIDTH-1:0] r_tx_c;
    logic [CNT_W-1:0]  r_ins_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    logic w_is_ctrl;
    logic w_is_idle;
    logic w_is_start;
    logic w_is_term;
    logic w_is_data;
    logic w_in_gap;
    logic w_frame_err;
    logic w_shim_rd;

    assign w_is_ctrl  = (pcs_c == c_SH_CTRL);
    assign w_is_idle  = w_is_ctrl && (pcs_d == c_IDLE_D);
    assign w_is_start = w_is_ctrl && (pcs_d[7:0] == 8'h78);
    assign w_is_data  = (pcs_c == c_SH_DATA);

    always_comb begin
        w_is_term = 1'b0;
        if (w_is_ctrl) begin
            case (pcs_d[7:0])
                8'h87, 8'h99, 8'haa, 8'hb4,
                8'hcc, 8'hd2, 8'he1, 8'hff: w_is_term = 1'b1;
                default:                    w_is_term = 1'b0;
            endcase
        end
    end

    assign w_in_gap    = (r_state == c_ST_GAP);
    assign w_frame_err = w_in_gap ? (w_is_data || w_is_term) : w_is_start;

    // reset_n gates the strobe so the FIFO is never popped while held in reset
    assign w_shim_rd = reset_n && pcs_valid && !shim_empty && w_is_idle &&
                       w_in_gap && (r_ipg_cnt >= c_MIN_IPG);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_GAP;
            r_ipg_cnt  <= c_MIN_IPG;
            r_tx_valid <= 1'b0;
            r_tx_d     <= c_IDLE_D;
            r_tx_c     <= c_SH_CTRL;
            r_ins_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_tx_valid <= pcs_valid;
            if (pcs_valid) begin
                r_tx_d <= w_shim_rd ? shim_d : pcs_d;
                r_tx_c <= w_shim_rd ? shim_c : pcs_c;
                if (w_shim_rd && (r_ins_cnt != '1)) begin
                    r_ins_cnt <= r_ins_cnt + 1'b1;
                end
                if (w_frame_err && (r_err_cnt != '1)) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                case (r_state)
                    c_ST_GAP: begin
                        if (w_is_start) begin
                            r_state <= c_ST_FRAME;
                        end else if (w_is_idle && (r_ipg_cnt < c_MIN_IPG)) begin
                            r_ipg_cnt <= r_ipg_cnt + 1'b1;
                        end
                    end
                    c_ST_FRAME: begin
                        if (w_is_term) begin
                            r_state   <= c_ST_GAP;
                            r_ipg_cnt <= 4'd0;
                        end
                    end
                    default: r_state <= c_ST_GAP;
                endcase
            end
        end
    end

    assign shim_rd  = w_shim_rd;
    assign tx_valid = r_tx_valid;
    assign tx_d     = r_tx_d;
    assign tx_c     = r_tx_c;
    assign ins_cnt  = r_ins_cnt;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_shim_idle_inserter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shim_idle_inserter
// Purpose  : Randomised and directed self-checking bench for shim_idle_inserter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shim_idle_inserter;

    localparam int MIN_IPG = 2;
    localparam int K_IDLE = 0, K_START = 1, K_TERM = 2, K_DATA = 3, K_OTHER = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pcs_valid = 1'b0;
    logic [63:0] pcs_d = 64'h1e;
    logic [1:0]  pcs_c = 2'b01;
    logic        shim_empty = 1'b1;
    logic [63:0] shim_d = '0;
    logic [1:0]  shim_c = '0;
    logic        shim_rd, tx_valid;
    logic [63:0] tx_d;
    logic [1:0]  tx_c;
    logic [31:0] ins_cnt, err_cnt;

    int checks = 0;
    int errors = 0;

    logic [65:0] fifo_q[$];
    bit          mdl_frame;
    int          mdl_ipg, mdl_err, mdl_ins;
    logic        exp_rd, exp_valid, obs_rd;
    logic [1:0]  exp_c;
    logic [63:0] exp_d;
    logic [7:0]  term_types[8] = '{8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};

    shim_idle_inserter #(.DWIDTH(64), .CWIDTH(2), .MIN_IPG(MIN_IPG), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .pcs_valid(pcs_valid), .pcs_d(pcs_d), .pcs_c(pcs_c),
        .shim_empty(shim_empty), .shim_d(shim_d), .shim_c(shim_c), .shim_rd(shim_rd),
        .tx_valid(tx_valid), .tx_d(tx_d), .tx_c(tx_c), .ins_cnt(ins_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int classify(input logic [1:0] c, input logic [63:0] d);
        if (c == 2'b10) return K_DATA;
        if (c != 2'b01) return K_OTHER;
        if (d == 64'h1e) return K_IDLE;
        if (d[7:0] == 8'h78) return K_START;
        foreach (term_types[i]) if (d[7:0] == term_types[i]) return K_TERM;
        return K_OTHER;
    endfunction

    task automatic fifo_refresh();
        shim_empty = (fifo_q.size() == 0);
        {shim_c, shim_d} = (fifo_q.size() != 0) ? fifo_q[0] : 66'd0;
    endtask

    task automatic mdl_reset();
        mdl_frame = 0; mdl_ipg = MIN_IPG; mdl_err = 0; mdl_ins = 0;
        exp_valid = 0; exp_c = 2'b01; exp_d = 64'h1e; exp_rd = 0;
    endtask

    // Drives one block, advances the reference model, then waits for the registered result.
    task automatic step(input logic v, input logic [1:0] c, input logic [63:0] d);
        int cls;
        pcs_valid = v; pcs_c = c; pcs_d = d;
        cls = classify(c, d);
        exp_rd = v && (fifo_q.size() != 0) && (cls == K_IDLE) && !mdl_frame && (mdl_ipg >= MIN_IPG);
        exp_valid = v;
        if (v) begin
            if (exp_rd) begin {exp_c, exp_d} = fifo_q[0]; mdl_ins++; end
            else begin exp_c = c; exp_d = d; end
            if (!mdl_frame) begin
                if (cls == K_START) mdl_frame = 1;
                else if (cls == K_DATA || cls == K_TERM) mdl_err++;
                else if (cls == K_IDLE && mdl_ipg < 15) mdl_ipg++;
            end else begin
                if (cls == K_TERM) begin mdl_frame = 0; mdl_ipg = 0; end
                else if (cls == K_START) mdl_err++;
            end
        end
        #2 obs_rd = shim_rd;
        @(posedge clk);
        #1;
        if (obs_rd && fifo_q.size() != 0) fifo_q.delete(0);
        fifo_refresh();
    endtask

    function automatic logic [65:0] rand_block(input int kind);
        logic [63:0] d;
        d = {$urandom, $urandom};
        case (kind)
            K_IDLE:  return {2'b01, 64'h1e};
            K_START: return {2'b01, d[63:8], 8'h78};
            K_TERM:  return {2'b01, d[63:8], term_types[$urandom_range(0, 7)]};
            K_DATA:  return {2'b10, d};
            default: return {($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11, d[63:8], 8'h4b};
        endcase
    endfunction

    task automatic test_reset();
        mdl_reset();
        fifo_q.push_back({2'b01, 64'hdead_beef_0000_0001});
        fifo_refresh();
        pcs_valid = 1; pcs_c = 2'b01; pcs_d = 64'h1e;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({shim_rd, tx_valid, tx_c, tx_d} !== {1'b0, 1'b0, 2'b01, 64'h1e}) begin
            errors++;
            $display("FAIL reset_out got rd=%b v=%b c=%b d=%h exp rd=0 v=0 c=01 d=1e", shim_rd, tx_valid, tx_c, tx_d);
        end
        checks++;
        if ({ins_cnt, err_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL reset_cnt got ins=%0d err=%0d exp 0 0", ins_cnt, err_cnt);
        end
        pcs_valid = 0;
        fifo_q.delete();
        fifo_refresh();
        reset_n = 1;
    endtask

    task automatic test_idle_passthru();
        int reads = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 2'b01, 64'h1e);
            reads += obs_rd;
            checks++;
            if ({obs_rd, tx_valid, tx_c, tx_d} !== {exp_rd, exp_valid, exp_c, exp_d}) begin
                errors++;
                $display("FAIL idle_pass cyc %0d got rd=%b v=%b c=%b d=%h exp rd=%b v=%b c=%b d=%h",
                         i, obs_rd, tx_valid, tx_c, tx_d, exp_rd, exp_valid, exp_c, exp_d);
            end
        end
        checks++;
        if (reads != 0 || ins_cnt !== 32'd0) begin
            errors++;
            $display("FAIL idle_pass_cnt got reads=%0d ins=%0d exp 0 0", reads, ins_cnt);
        end
    endtask

    task automatic test_fifo_drain();
        for (int i = 1; i <= 3; i++) fifo_q.push_back({2'b01, 56'hA5A5A5A5A5A5A5, 8'(i)});
        fifo_refresh();
        for (int i = 0; i < 5; i++) begin
            step(1, 2'b01, 64'h1e);
            checks++;
            if ({obs_rd, tx_valid, tx_c, tx_d} !== {exp_rd, exp_valid, exp_c, exp_d}) begin
                errors++;
                $display("FAIL drain cyc %0d got rd=%b v=%b c=%b d=%h exp rd=%b v=%b c=%b d=%h",
                         i, obs_rd, tx_valid, tx_c, tx_d, exp_rd, exp_valid, exp_c, exp_d);
            end
        end
        checks++;
        if (ins_cnt !== 32'd3 || fifo_q.size() != 0) begin
            errors++;
            $display("FAIL drain_cnt got ins=%0d fifo=%0d exp 3 0", ins_cnt, fifo_q.size());
        end
    endtask

    task automatic test_min_ipg();
        logic [65:0] frame[$];
        logic [3:0]  rd_bits;
        for (int i = 0; i < 4; i++) fifo_q.push_back({2'b01, 56'hC3C3C3C3C3C3C3, 8'(i)});
        fifo_refresh();
        frame.push_back(rand_block(K_START));
        for (int i = 0; i < 4; i++) frame.push_back(rand_block(K_DATA));
        frame.push_back({2'b01, 56'h0, 8'h87});
        for (int i = 0; i < 4; i++) frame.push_back({2'b01, 64'h1e});
        foreach (frame[i]) begin
            step(1, frame[i][65:64], frame[i][63:0]);
            if (i >= 6) rd_bits[i-6] = obs_rd;
            checks++;
            if ({obs_rd, tx_valid, tx_c, tx_d} !== {exp_rd, exp_valid, exp_c, exp_d}) begin
                errors++;
                $display("FAIL min_ipg cyc %0d got rd=%b v=%b c=%b d=%h exp rd=%b v=%b c=%b d=%h",
                         i, obs_rd, tx_valid, tx_c, tx_d, exp_rd, exp_valid, exp_c, exp_d);
            end
        end
        checks++;
        if (rd_bits !== 4'b1100) begin
            errors++;
            $display("FAIL min_ipg_rd got %b exp 1100", rd_bits);
        end
    endtask

    task automatic test_start_wins();
        logic [65:0] seq[$];
        int reads = 0;
        seq.push_back({2'b01, 64'h1e});
        seq.push_back(rand_block(K_START));
        seq.push_back(rand_block(K_DATA));
        seq.push_back(rand_block(K_DATA));
        seq.push_back({2'b01, 56'h0, 8'hff});
        foreach (seq[i]) begin
            step(1, seq[i][65:64], seq[i][63:0]);
            reads += obs_rd;
            checks++;
            if ({obs_rd, tx_valid, tx_c, tx_d} !== {exp_rd, exp_valid, exp_c, exp_d}) begin
                errors++;
                $display("FAIL start_wins cyc %0d got rd=%b v=%b c=%b d=%h exp rd=%b v=%b c=%b d=%h",
                         i, obs_rd, tx_valid, tx_c, tx_d, exp_rd, exp_valid, exp_c, exp_d);
            end
            if (i == 1) begin
                checks++;
                if ({tx_c, tx_d} !== seq[1]) begin
                    errors++;
                    $display("FAIL start_out got %h exp %h", {tx_c, tx_d}, seq[1]);
                end
            end
        end
        checks++;
        if (reads != 1 || fifo_q.size() != 1) begin
            errors++;
            $display("FAIL start_wins_rd got reads=%0d fifo=%0d exp 1 1", reads, fifo_q.size());
        end
        fifo_q.delete();
        fifo_refresh();
    endtask

    task automatic test_framing_err();
        logic [65:0] seq[$];
        int e0;
        e0 = mdl_err;
        seq.push_back(rand_block(K_DATA));
        seq.push_back(rand_block(K_START));
        seq.push_back(rand_block(K_START));
        foreach (seq[i]) begin
            step(1, seq[i][65:64], seq[i][63:0]);
            checks++;
            if ({tx_valid, tx_c, tx_d} !== {1'b1, seq[i]}) begin
                errors++;
                $display("FAIL frame_err_pass cyc %0d got v=%b %h exp v=1 %h", i, tx_valid, {tx_c, tx_d}, seq[i]);
            end
        end
        checks++;
        if (err_cnt !== 32'(e0 + 2)) begin
            errors++;
            $display("FAIL frame_err_cnt got %0d exp %0d", err_cnt, e0 + 2);
        end
        step(1, 2'b01, {56'h0, 8'hcc});
    endtask

    task automatic test_random();
        logic [65:0] b;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 6)
                fifo_q.push_back({2'($urandom), $urandom, $urandom});
            fifo_refresh();
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4, 5, 6, 7: b = rand_block(K_IDLE);
                8, 9:                   b = rand_block(K_START);
                10, 11, 12, 13, 14:     b = rand_block(K_DATA);
                15, 16:                 b = rand_block(K_TERM);
                default:                b = rand_block(K_OTHER);
            endcase
            step($urandom_range(0, 9) != 0, b[65:64], b[63:0]);
            checks++;
            if ({obs_rd, tx_valid, tx_c, tx_d} !== {exp_rd, exp_valid, exp_c, exp_d}) begin
                errors++;
                $display("FAIL random cyc %0d got rd=%b v=%b c=%b d=%h exp rd=%b v=%b c=%b d=%h",
                         i, obs_rd, tx_valid, tx_c, tx_d, exp_rd, exp_valid, exp_c, exp_d);
            end
        end
        checks++;
        if (ins_cnt !== 32'(mdl_ins) || err_cnt !== 32'(mdl_err)) begin
            errors++;
            $display("FAIL random_cnt got ins=%0d err=%0d exp %0d %0d", ins_cnt, err_cnt, mdl_ins, mdl_err);
        end
    endtask

    task automatic test_reset_midframe();
        step(1, 2'b01, {56'h0, 8'h78});
        step(1, 2'b10, 64'h0123_4567_89ab_cdef);
        step(1, 2'b01, {56'h0, 8'hb4});
        step(1, 2'b01, 64'h1e);
        step(1, 2'b01, 64'h1e);
        fifo_q.push_back({2'b01, 64'hfeed_face_0000_0009});
        fifo_refresh();
        pcs_valid = 1; pcs_c = 2'b01; pcs_d = 64'h1e;
        #2;
        checks++;
        if (shim_rd !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pending got rd=%b exp 1", shim_rd);
        end
        reset_n = 0;
        #1;
        checks++;
        if ({shim_rd, tx_valid, tx_c, tx_d} !== {1'b0, 1'b0, 2'b01, 64'h1e}) begin
            errors++;
            $display("FAIL midreset_out got rd=%b v=%b c=%b d=%h exp rd=0 v=0 c=01 d=1e", shim_rd, tx_valid, tx_c, tx_d);
        end
        checks++;
        if ({ins_cnt, err_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL midreset_cnt got ins=%0d err=%0d exp 0 0", ins_cnt, err_cnt);
        end
        pcs_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        mdl_reset();
        fifo_q.delete();
        fifo_refresh();
        step(1, 2'b10, 64'h5555_aaaa_5555_aaaa);
        checks++;
        if (err_cnt !== 32'd1 || {tx_c, tx_d} !== {2'b10, 64'h5555_aaaa_5555_aaaa}) begin
            errors++;
            $display("FAIL post_reset_data got err=%0d %h exp 1 %h", err_cnt, {tx_c, tx_d}, {2'b10, 64'h5555_aaaa_5555_aaaa});
        end
    endtask

    initial begin
        fifo_refresh();
        test_reset();
        test_idle_passthru();
        test_fifo_drain();
        test_min_ipg();
        test_start_wins();
        test_framing_err();
        test_random();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
